// File: rtl/glm_l2reg_sequencer_if.sv
// Command and unit-side bus of the GLM L2-regularization sequencer.
// The slave modport is the sequencer view; the master modport is the
// decoder/unit environment that drives commands and completion.
interface glm_l2reg_sequencer_if;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [31:0]          cmd_total_lines;
    logic [15:0]          cmd_chunk_lines;
    logic [3:0][31:0]     cmd_props;
    logic [31:0]          cmd_lambda;
    logic                 abort_req;
    logic                 l2_op_start;
    logic                 l2_op_done;
    logic [5:0][31:0]     l2_regs;

    modport slave (
        input  cmd_valid, cmd_total_lines, cmd_chunk_lines, cmd_props, cmd_lambda,
        input  abort_req, l2_op_done,
        output cmd_ready, l2_op_start, l2_regs
    );

    modport master (
        output cmd_valid, cmd_total_lines, cmd_chunk_lines, cmd_props, cmd_lambda,
        output abort_req, l2_op_done,
        input  cmd_ready, l2_op_start, l2_regs
    );
endinterface

// File: rtl/glm_l2reg_sequencer.sv
// Chunking command sequencer for the GLM L2-regularization unit.
// Splits one update command into operations of at most MAX_CHUNK lines,
// programs the 6-word register set per chunk and advances line offsets.
// Optional GLM_L2REG_SEQ_PERF_EN adds busy/wait cycle counters.
module glm_l2reg_sequencer #(
    parameter int MAX_CHUNK     = 256,
    parameter int OFFSET_STRIDE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    glm_l2reg_sequencer_if.slave  bus,
    output logic                  seq_done,
    output logic                  seq_aborted,
    output logic                  busy,
    output logic [15:0]           chunks_issued
`ifdef GLM_L2REG_SEQ_PERF_EN
    ,
    output logic [31:0]           perf_busy_cycles,
    output logic [31:0]           perf_wait_cycles
`endif
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ISSUE  = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    localparam logic [15:0] MAX_C = 16'(MAX_CHUNK);

    typedef logic [5:0][31:0] regs_t;

    logic [1:0]       state_q, state_d;
    logic [31:0]      remaining_q, remaining_d;
    logic [15:0]      offset_q, offset_d;
    logic [15:0]      chunk_q, chunk_d;
    logic [3:0][31:0] props_q, props_d;
    logic [31:0]      lambda_q, lambda_d;
    regs_t            regs_q, regs_d;
    logic             abort_q, abort_d;
    logic [15:0]      chunks_q, chunks_d;

    logic [15:0]      req_chunk;
    logic [15:0]      eff_chunk;
    logic [31:0]      rem_next;
    logic [15:0]      off_next;
    logic             accept;

    // Register image for the next chunk: line count plus offset-adjusted props.
    function automatic regs_t build_regs(input logic [31:0] rem, input logic [15:0] off,
                                         input logic [15:0] chunk, input logic [3:0][31:0] props,
                                         input logic [31:0] lam);
        regs_t       r;
        logic [15:0] n;
        logic [31:0] step;
        n    = (rem < {16'h0, chunk}) ? rem[15:0] : chunk;
        step = 32'(off) * 32'(OFFSET_STRIDE);
        r[0] = {16'h0, n};
        for (int k = 0; k < 4; k++) begin
            // zero base marks copy mode and is never offset
            r[k+1] = (props[k] == 32'h0) ? 32'h0
                                         : {props[k][31:16], props[k][15:0] + step[15:0]};
        end
        r[5] = lam;
        return r;
    endfunction

    // Next-state logic: accept, issue, wait for completion, finish.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        offset_d    = offset_q;
        chunk_d     = chunk_q;
        props_d     = props_q;
        lambda_d    = lambda_q;
        regs_d      = regs_q;
        abort_d     = abort_q;
        chunks_d    = chunks_q;
        req_chunk   = (bus.cmd_chunk_lines == 16'h0) ? MAX_C : bus.cmd_chunk_lines;
        eff_chunk   = (req_chunk > MAX_C) ? MAX_C : req_chunk;
        rem_next    = remaining_q - {16'h0, regs_q[0][15:0]};
        off_next    = offset_q + regs_q[0][15:0];
        accept      = (state_q == IDLE) && bus.cmd_valid;
        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (bus.cmd_valid) begin
                    props_d     = bus.cmd_props;
                    lambda_d    = bus.cmd_lambda;
                    chunk_d     = eff_chunk;
                    remaining_d = bus.cmd_total_lines;
                    offset_d    = 16'h0;
                    chunks_d    = 16'h0;
                    if (bus.cmd_total_lines == 32'h0) begin
                        state_d = FINISH;
                    end else begin
                        state_d = ISSUE;
                        regs_d  = build_regs(bus.cmd_total_lines, 16'h0, eff_chunk,
                                             bus.cmd_props, bus.cmd_lambda);
                    end
                end
            end
            ISSUE: begin
                chunks_d = chunks_q + 16'h1;
                state_d  = WAIT;
                if (bus.abort_req) abort_d = 1'b1;
            end
            WAIT: begin
                if (bus.abort_req) abort_d = 1'b1;
                if (bus.l2_op_done) begin
                    remaining_d = rem_next;
                    offset_d    = off_next;
                    if (rem_next == 32'h0 || abort_q || bus.abort_req) begin
                        state_d = FINISH;
                    end else begin
                        state_d = ISSUE;
                        regs_d  = build_regs(rem_next, off_next, chunk_q, props_q, lambda_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= 32'h0;
            offset_q    <= 16'h0;
            chunk_q     <= 16'h0;
            props_q     <= '0;
            lambda_q    <= 32'h0;
            regs_q      <= '0;
            abort_q     <= 1'b0;
            chunks_q    <= 16'h0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            offset_q    <= offset_d;
            chunk_q     <= chunk_d;
            props_q     <= props_d;
            lambda_q    <= lambda_d;
            regs_q      <= regs_d;
            abort_q     <= abort_d;
            chunks_q    <= chunks_d;
        end
    end

    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.l2_op_start = (state_q == ISSUE);
    assign bus.l2_regs     = regs_q;
    assign seq_done        = (state_q == FINISH);
    assign seq_aborted     = (state_q == FINISH) && abort_q;
    assign busy            = (state_q != IDLE);
    assign chunks_issued   = chunks_q;

`ifdef GLM_L2REG_SEQ_PERF_EN
    logic [31:0] perf_busy_q, perf_busy_d;
    logic [31:0] perf_wait_q, perf_wait_d;

    // Per-command counters, cleared on accept and held once idle.
    always_comb begin
        perf_busy_d = perf_busy_q;
        perf_wait_d = perf_wait_q;
        if (accept) begin
            perf_busy_d = 32'h0;
            perf_wait_d = 32'h0;
        end else begin
            if (state_q != IDLE) perf_busy_d = perf_busy_q + 32'h1;
            if (state_q == WAIT) perf_wait_d = perf_wait_q + 32'h1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_busy_q <= 32'h0;
            perf_wait_q <= 32'h0;
        end else begin
            perf_busy_q <= perf_busy_d;
            perf_wait_q <= perf_wait_d;
        end
    end

    assign perf_busy_cycles = perf_busy_q;
    assign perf_wait_cycles = perf_wait_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif
endmodule

// File: tb/tb_glm_l2reg_sequencer.sv
// Self-checking bench for glm_l2reg_sequencer: table of command vectors
// with hand-computed per-chunk register images, plus directed sequences
// for zero-length commands and spurious completions.
module tb_glm_l2reg_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        seq_done, seq_aborted, busy;
    logic [15:0] chunks_issued;
`ifdef GLM_L2REG_SEQ_PERF_EN
    logic [31:0] perf_busy_cycles, perf_wait_cycles;
`endif

    glm_l2reg_sequencer_if bus();

    glm_l2reg_sequencer dut (
        .clk           (clk),
        .reset         (rst),
        .bus           (bus),
        .seq_done      (seq_done),
        .seq_aborted   (seq_aborted),
        .busy          (busy),
        .chunks_issued (chunks_issued)
`ifdef GLM_L2REG_SEQ_PERF_EN
        ,
        .perf_busy_cycles (perf_busy_cycles),
        .perf_wait_cycles (perf_wait_cycles)
`endif
    );

    always #5 clk = ~clk;

    // mode: 0 plain, 1 abort pulse mid-WAIT of chunk mchunk,
    //       2 abort together with done of chunk mchunk, 3 reset mid-WAIT of chunk mchunk
    typedef struct {
        logic [31:0]      total;
        logic [15:0]      chunk;
        logic [3:0][31:0] props;
        int               delay;
        int               mode;
        int               mchunk;
        int               starts;
        logic [2:0][15:0] n;
        logic [2:0][31:0] p1;
        logic [2:0][31:0] p2;
        logic             aborted;
    } vec_t;

    vec_t vt [8];
    int   n_total = 0;
    int   n_bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_vec(input int i, input logic [31:0] total, input logic [15:0] chunk,
                           input logic [31:0] q0, input logic [31:0] q1,
                           input logic [31:0] q2, input logic [31:0] q3,
                           input int delay, input int mode, input int mchunk, input int starts,
                           input logic [15:0] n0, input logic [15:0] n1, input logic [15:0] n2,
                           input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                           input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
                           input logic aborted);
        vt[i].total   = total;
        vt[i].chunk   = chunk;
        vt[i].props   = {q3, q2, q1, q0};
        vt[i].delay   = delay;
        vt[i].mode    = mode;
        vt[i].mchunk  = mchunk;
        vt[i].starts  = starts;
        vt[i].n       = {n2, n1, n0};
        vt[i].p1      = {a2, a1, a0};
        vt[i].p2      = {b2, b1, b0};
        vt[i].aborted = aborted;
    endtask

    task automatic run_vec(input int idx);
        vec_t             v;
        int               started;
        int               cnt;
        int               since;
        bit               lat_pend;
        bit               fin;
        logic [5:0][31:0] held;
        v        = vt[idx];
        started  = 0;
        cnt      = 0;
        since    = 0;
        lat_pend = 1'b0;
        fin      = 1'b0;
        held     = '0;
        bus.cmd_total_lines = v.total;
        bus.cmd_chunk_lines = v.chunk;
        bus.cmd_props       = v.props;
        bus.cmd_lambda      = 32'h3DCC0000 + 32'(idx);
        bus.cmd_valid       = 1'b1;
        chk("ready_idle", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        chk("accept_lat", 32'(bus.l2_op_start), 32'd1);
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            bus.l2_op_done = 1'b0;
            bus.abort_req  = 1'b0;
            if (lat_pend) begin
                chk("done_lat", 32'(bus.l2_op_start | seq_done), 32'd1);
                lat_pend = 1'b0;
            end
            if (bus.l2_op_start) begin
                if (started < 3) begin
                    chk("regs_lines", bus.l2_regs[0], {16'h0, v.n[started]});
                    chk("regs_p1", bus.l2_regs[1], v.p1[started]);
                    chk("regs_p2", bus.l2_regs[2], v.p2[started]);
                    chk("regs_lambda", bus.l2_regs[5], 32'h3DCC0000 + 32'(idx));
                end
                held    = bus.l2_regs;
                started = started + 1;
                cnt     = v.delay;
                since   = 0;
            end else if (seq_done) begin
                chk("aborted", 32'(seq_aborted), 32'(v.aborted));
                chk("starts", 32'(started), 32'(v.starts));
                chk("chunks_issued", 32'(chunks_issued), 32'(v.starts));
                fin = 1'b1;
            end else begin
                since = since + 1;
                chk("hold_regs", 32'(bus.l2_regs != held), 32'd0);
                if (v.mode == 3 && started == v.mchunk && since == 2) begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    chk("rst_busy", 32'(busy), 32'd0);
                    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
                    chk("rst_regs", 32'(|bus.l2_regs), 32'd0);
                    chk("rst_chunks", 32'(chunks_issued), 32'd0);
                    chk("rst_starts", 32'(started), 32'(v.starts));
                    return;
                end
                if (v.mode == 1 && started == v.mchunk && since == 2) bus.abort_req = 1'b1;
                if (cnt > 0) begin
                    cnt = cnt - 1;
                    if (cnt == 0) begin
                        bus.l2_op_done = 1'b1;
                        lat_pend       = 1'b1;
                        if (v.mode == 2 && started == v.mchunk) bus.abort_req = 1'b1;
                    end
                end
            end
            if (!fin) tick();
        end
        if (!fin) begin
            n_total++;
            n_bad++;
            $display("FAIL timeout vec=%0d actual=no_seq_done required=seq_done", idx);
        end else begin
            tick();
            chk("done_pulse", 32'(seq_done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_ready", 32'(bus.cmd_ready), 32'd1);
        end
    endtask

    initial begin
        rst                 = 1'b1;
        bus.cmd_valid       = 1'b0;
        bus.cmd_total_lines = 32'h0;
        bus.cmd_chunk_lines = 16'h0;
        bus.cmd_props       = '0;
        bus.cmd_lambda      = 32'h0;
        bus.abort_req       = 1'b0;
        bus.l2_op_done      = 1'b0;

        //      idx total chunk props[0..3]                                   dly mode mc st  n0  n1  n2   p1[0..2]                          p2[0..2]                          ab
        set_vec(0, 600, 0,   32'h00010000, 32'h00020010, 32'h00030020, 32'h00040030, 20, 0, 0, 3, 256, 256, 88,
                32'h00010000, 32'h00010100, 32'h00010200, 32'h00020010, 32'h00020110, 32'h00020210, 1'b0);
        set_vec(1, 300, 100, 32'h00000000, 32'h00020010, 32'h00030020, 32'h00040030, 5, 0, 0, 3, 100, 100, 100,
                32'h0, 32'h0, 32'h0, 32'h00020010, 32'h00020074, 32'h000200D8, 1'b0);
        set_vec(2, 1000, 100, 32'h00010000, 32'h00020010, 32'h00030020, 32'h00040030, 6, 1, 2, 2, 100, 100, 0,
                32'h00010000, 32'h00010064, 32'h0, 32'h00020010, 32'h00020074, 32'h0, 1'b1);
        set_vec(3, 300, 300, 32'h00010000, 32'h00020010, 32'h00030020, 32'h00040030, 3, 0, 0, 2, 256, 44, 0,
                32'h00010000, 32'h00010100, 32'h0, 32'h00020010, 32'h00020110, 32'h0, 1'b0);
        set_vec(4, 500, 100, 32'h00010000, 32'h00020010, 32'h00030020, 32'h00040030, 4, 2, 1, 1, 100, 0, 0,
                32'h00010000, 32'h0, 32'h0, 32'h00020010, 32'h0, 32'h0, 1'b1);
        set_vec(5, 40, 16,   32'h1234FFF0, 32'h00020010, 32'h00000000, 32'h00040030, 2, 0, 0, 3, 16, 16, 8,
                32'h1234FFF0, 32'h12340000, 32'h12340010, 32'h00020010, 32'h00020020, 32'h00020030, 1'b0);
        set_vec(6, 300, 100, 32'h00010000, 32'h00020010, 32'h00030020, 32'h00040030, 8, 3, 2, 2, 100, 100, 0,
                32'h00010000, 32'h00010064, 32'h0, 32'h00020010, 32'h00020074, 32'h0, 1'b0);
        set_vec(7, 5, 0,     32'h00010000, 32'h00020010, 32'h00030020, 32'h00040030, 1, 0, 0, 1, 5, 0, 0,
                32'h00010000, 32'h0, 32'h0, 32'h00020010, 32'h0, 32'h0, 1'b0);

        tick();
        tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ready", 32'(bus.cmd_ready), 32'd1);
        chk("reset_start", 32'(bus.l2_op_start), 32'd0);
        chk("reset_done", 32'(seq_done), 32'd0);
        chk("reset_aborted", 32'(seq_aborted), 32'd0);
        chk("reset_chunks", 32'(chunks_issued), 32'd0);
        chk("reset_regs", 32'(|bus.l2_regs), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_vec(i);

        // zero-length command: straight to FINISH in the cycle after accept
        bus.cmd_total_lines = 32'h0;
        bus.cmd_chunk_lines = 16'h0;
        bus.cmd_valid       = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        chk("zero_done", 32'(seq_done), 32'd1);
        chk("zero_start", 32'(bus.l2_op_start), 32'd0);
        chk("zero_aborted", 32'(seq_aborted), 32'd0);
        chk("zero_chunks", 32'(chunks_issued), 32'd0);
        tick();
        chk("zero_idle", 32'(busy), 32'd0);
        chk("zero_pulse", 32'(seq_done), 32'd0);

        // spurious done (and abort) in IDLE, then spurious done in ISSUE
        bus.l2_op_done = 1'b1;
        bus.abort_req  = 1'b1;
        tick();
        bus.l2_op_done = 1'b0;
        bus.abort_req  = 1'b0;
        chk("spur_idle_busy", 32'(busy), 32'd0);
        chk("spur_idle_start", 32'(bus.l2_op_start), 32'd0);
        chk("spur_idle_done", 32'(seq_done), 32'd0);
        bus.cmd_total_lines = 32'd5;
        bus.cmd_valid       = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        chk("spur_issue_start", 32'(bus.l2_op_start), 32'd1);
        bus.l2_op_done = 1'b1;
        tick();
        bus.l2_op_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("spur_issue_wait", 32'({busy, bus.l2_op_start, seq_done}), 32'b100);
            tick();
        end
        bus.l2_op_done = 1'b1;
        tick();
        bus.l2_op_done = 1'b0;
        chk("spur_final_done", 32'(seq_done), 32'd1);
        chk("spur_final_abort", 32'(seq_aborted), 32'd0);
        chk("spur_final_chunks", 32'(chunks_issued), 32'd1);
        tick();

        run_vec(6);
        run_vec(7);
`ifdef GLM_L2REG_SEQ_PERF_EN
        chk("perf_busy", perf_busy_cycles, 32'd3);
        chk("perf_wait", perf_wait_cycles, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
